// File: rtl/alu_pkg.sv
// Shared function codes, FSM state type and build-time feature flag for alu_seq_unit.
// Optional multiplier is enabled by defining the macro ALU_MUL_EN.
package alu_pkg;

    localparam logic [3:0] FN_PASS_A = 4'd0;
    localparam logic [3:0] FN_ADD    = 4'd1;
    localparam logic [3:0] FN_SUB    = 4'd2;
    localparam logic [3:0] FN_AND    = 4'd3;
    localparam logic [3:0] FN_OR     = 4'd4;
    localparam logic [3:0] FN_XOR    = 4'd5;
    localparam logic [3:0] FN_NOT    = 4'd6;
    localparam logic [3:0] FN_INC    = 4'd7;
    localparam logic [3:0] FN_DEC    = 4'd8;
    localparam logic [3:0] FN_PASS_B = 4'd9;
    localparam logic [3:0] FN_SHL    = 4'd10;
    localparam logic [3:0] FN_SHR    = 4'd11;
    localparam logic [3:0] FN_SAR    = 4'd12;
    localparam logic [3:0] FN_MUL    = 4'd13;
    localparam logic [3:0] FN_LT     = 4'd14;
    localparam logic [3:0] FN_ZERO   = 4'd15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

`ifdef ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one bit of b per cycle, WIDTH cycles after start.
// Only instantiated when ALU_MUL_EN is defined.
module alu_mul_iter #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;
    logic               busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
        end else if (start) begin
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            cnt    <= CW'(WIDTH);
            busy   <= 1'b1;
        end else if (busy) begin
            if (cnt != '0) begin
                if (mplier[0]) acc <= acc + mcand;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt - CW'(1);
            end else begin
                busy <= 1'b0;
            end
        end
    end

    // Product is final once every multiplier bit has been consumed.
    assign done    = busy && (cnt == '0);
    assign product = acc;

endmodule

// File: rtl/alu_seq_unit.sv
// Handshaked registered ALU with a wrapping completed-transaction counter.
// Define ALU_MUL_EN to make F=13 an iterative WIDTH-cycle multiply; otherwise F=13 yields 0.
module alu_seq_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic [3:0]       F,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] D,
    output logic             Co,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] op_count
);

    state_t state, state_next;

    logic             accept;
    logic             mul_done;
    logic [WIDTH-1:0] comb_d;
    logic             comb_co;
    logic [WIDTH:0]   sum, diff, inc, dec;

    localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

    assign accept = in_valid && in_ready;

    // Borrow falls out as the top bit of the widened difference.
    assign sum  = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, Cin};
    assign diff = {1'b0, A} - {1'b0, B} - {{WIDTH{1'b0}}, Cin};
    assign inc  = {1'b0, A} + ONE;
    assign dec  = {1'b0, A} - ONE;

`ifdef ALU_MUL_EN
    logic [2*WIDTH-1:0] mul_prod;

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (accept && (F == FN_MUL)),
        .a       (A),
        .b       (B),
        .done    (mul_done),
        .product (mul_prod)
    );
`else
    assign mul_done = 1'b0;
`endif

    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        comb_d  = '0;
        comb_co = 1'b0;
        case (F)
            FN_PASS_A: comb_d = A;
            FN_ADD:    {comb_co, comb_d} = sum;
            FN_SUB:    {comb_co, comb_d} = diff;
            FN_AND:    comb_d = A & B;
            FN_OR:     comb_d = A | B;
            FN_XOR:    comb_d = A ^ B;
            FN_NOT:    comb_d = ~A;
            FN_INC:    {comb_co, comb_d} = inc;
            FN_DEC:    {comb_co, comb_d} = dec;
            FN_PASS_B: comb_d = B;
            FN_SHL:    begin comb_d = {A[WIDTH-2:0], 1'b0};     comb_co = A[WIDTH-1]; end
            FN_SHR:    begin comb_d = {1'b0, A[WIDTH-1:1]};     comb_co = A[0];       end
            FN_SAR:    begin comb_d = {A[WIDTH-1], A[WIDTH-1:1]}; comb_co = A[0];     end
            FN_LT:     comb_d = {{(WIDTH-1){1'b0}}, (A < B)};
            FN_MUL, FN_ZERO: comb_d = '0;
            default:   comb_d = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = (MUL_EN && (F == FN_MUL)) ? EXEC : DONE;
            EXEC: if (mul_done) state_next = DONE;
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Result registers load only on entry to DONE, so they hold under backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            D  <= '0;
            Co <= 1'b0;
        end else if ((state == IDLE) && (state_next == DONE)) begin
            D  <= comb_d;
            Co <= comb_co;
        end
`ifdef ALU_MUL_EN
        else if ((state == EXEC) && mul_done) begin
            D  <= mul_prod[WIDTH-1:0];
            Co <= |mul_prod[2*WIDTH-1:WIDTH];
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                         op_count <= '0;
        else if (out_valid && out_ready) op_count <= op_count + CNT_W'(1);
    end

endmodule

// File: tb/tb_alu_seq_unit.sv
// Scoreboard bench for alu_seq_unit: expected results queued at acceptance, checked by a monitor.
// Build with or without ALU_MUL_EN; the reference model follows the same macro.
module tb_alu_seq_unit;

    localparam int W  = 4;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  A = '0, B = '0;
    logic          Cin = 1'b0;
    logic [3:0]    F = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  D;
    logic          Co;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [CW-1:0] op_count;

    alu_seq_unit dut (
        .clk(clk), .rst(rst), .A(A), .B(B), .Cin(Cin), .F(F),
        .in_valid(in_valid), .in_ready(in_ready), .D(D), .Co(Co),
        .out_valid(out_valid), .out_ready(out_ready), .op_count(op_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int d;
        int co;
        int lat;
        int acc;
    } exp_t;

    exp_t          sb[$];
    bit            seen = 1'b0;
    logic [CW-1:0] hs_count = '0;
    bit            rand_ready = 1'b0;
    int            tests = 0;
    int            fails = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference behaviour written with plain integer arithmetic.
    function automatic exp_t model(input int a, input int b, input int cin, input int f);
        exp_t e;
        int   r;
        int   lim;
        lim   = 1 << W;
        r     = 0;
        e.co  = 0;
        e.lat = 0;
        e.acc = 0;
        case (f)
            0:  r = a;
            1:  begin r = a + b + cin; e.co = (r >= lim); end
            2:  begin r = a - b - cin; e.co = (r < 0);    end
            3:  r = a & b;
            4:  r = a | b;
            5:  r = a ^ b;
            6:  r = lim - 1 - a;
            7:  begin r = a + 1; e.co = (r >= lim); end
            8:  begin r = a - 1; e.co = (r < 0);    end
            9:  r = b;
            10: begin r = a * 2; e.co = (a >= lim / 2); end
            11: begin r = a / 2; e.co = a % 2; end
            12: begin r = a / 2 + ((a >= lim / 2) ? lim / 2 : 0); e.co = a % 2; end
`ifdef ALU_MUL_EN
            13: begin r = a * b; e.co = (r >= lim); e.lat = W + 1; end
`else
            13: r = 0;
`endif
            14: r = (a < b) ? 1 : 0;
            default: r = 0;
        endcase
        e.d = r & (lim - 1);
        return e;
    endfunction

    task automatic issue(input int a, input int b, input int cin, input int f);
        exp_t e;
        bit   got;
        A = W'(a); B = W'(b); Cin = 1'(cin); F = 4'(f);
        in_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (in_ready) got = 1'b1;
        end
        if (!got) begin
            check("accept_timeout", in_ready, 1);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            e     = model(a, b, cin, f);
            e.acc = cyc;
            sb.push_back(e);
            #1;
            in_valid = 1'b0;
            A = W'($urandom); B = W'($urandom); F = 4'($urandom);
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
        check("drain_timeout", sb.size(), 0);
        @(posedge clk);
        #2;
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        sb.delete();
        seen     = 1'b0;
        hs_count = '0;
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    // Monitor: compares every presented result with the scoreboard head.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            check("in_ready_low_in_done", in_ready, 0);
            check("scoreboard_depth", sb.size(), 1);
            if (sb.size() > 0) begin
                if (!seen) begin
                    check("latency", cyc - sb[0].acc, sb[0].lat);
                    check("op_count", op_count, hs_count);
                    seen = 1'b1;
                end
                check("D", D, sb[0].d);
                check("Co", Co, sb[0].co);
                if (out_ready) begin
                    void'(sb.pop_front());
                    seen = 1'b0;
                    hs_count++;
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        logic [CW-1:0] cnt_before;

        repeat (2) @(posedge clk);
        #2;
        check("rst_D", D, 0);
        check("rst_Co", Co, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_op_count", op_count, 0);
        rst = 1'b0;
        @(posedge clk);
        #2;
        check("idle_out_valid", out_valid, 0);
        check("idle_in_ready", in_ready, 1);

        // Directed cases: add with carry, subtract with borrow, arithmetic shift, multiply.
        issue(1, 1, 1, 1);
        issue(15, 1, 0, 1);
        wait_drain();
        check("op_count_after_two", op_count, 2);
        issue(0, 1, 0, 2);
        issue(9, 0, 0, 12);
        issue(3, 5, 0, 13);
        issue(15, 15, 0, 13);
        wait_drain();

        // Backpressure: result held, new requests ignored until consumed.
        cnt_before = op_count;
        out_ready  = 1'b0;
        issue(0, 1, 0, 9);
        A = 4'd5; B = 4'd3; F = 4'd1; in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("bp_in_ready", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
        end
        @(posedge clk);
        #2;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_drain();
        check("bp_op_count", op_count, cnt_before + CW'(1));

        // Reset while a result waits in DONE discards it.
        out_ready = 1'b0;
        issue(6, 3, 0, 5);
        repeat (2) @(posedge clk);
        #2;
        reset_pulse();
        out_ready = 1'b1;
        repeat (W + 3) begin
            @(negedge clk);
            check("rst_done_out_valid", out_valid, 0);
            check("rst_done_in_ready", in_ready, 1);
        end
        check("rst_done_op_count", op_count, 0);

`ifdef ALU_MUL_EN
        // Reset two cycles into a multiply discards it.
        issue(7, 9, 0, 13);
        repeat (2) @(posedge clk);
        #2;
        reset_pulse();
        repeat (W + 3) begin
            @(negedge clk);
            check("rst_exec_out_valid", out_valid, 0);
            check("rst_exec_in_ready", in_ready, 1);
        end
        check("rst_exec_op_count", op_count, 0);
        @(posedge clk);
        #2;
`endif

        // Random traffic with random backpressure; long enough to wrap op_count.
        rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            int gap;
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                @(posedge clk);
                #2;
            end
            issue($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 1), $urandom_range(0, 15));
        end
        rand_ready = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        wait_drain();
        check("final_op_count", op_count, hs_count);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
